// File: rtl/tone_pkg.sv
// tone_pkg: shared types and constants for the tone detection chain
package tone_pkg;
   localparam int MAG_WIDTH = 8;
   localparam logic EVT_ONSET = 1'b1;
   localparam logic EVT_OFFSET = 1'b0;
   typedef enum logic [1:0] {IDLE, ATTACK, ON, RELEASE} tone_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter adding inc when en, clearing on clr, sticking at all-ones
// ports: clk, rst (sync, high), clr (sync clear, beats en), en, inc [IW], q [W]
module sat_counter #(
   parameter int W = 16,
   parameter int IW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [IW-1:0] inc,
   output logic [W-1:0]  q
);
   logic [W:0] sum;
   assign sum = {1'b0, q} + (W+1)'(inc);
   always_ff @(posedge clk)
      if (rst || clr) q <= '0;
      else if (en) q <= sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/tone_qualifier.sv
// tone_qualifier: hysteresis/min-run debounce of a magnitude stream into tone level and onset/offset events
// ports: i_clk, i_rst (sync, high), i_valid, i_data [DATA_WIDTH_IN] in;
//        o_tone level, o_evt_valid strobe, o_evt_onset (1 onset / 0 offset), o_evt_len [LEN_WIDTH] out
module tone_qualifier
   import tone_pkg::*;
#(
   parameter int DATA_WIDTH_IN = MAG_WIDTH,
   parameter int THR_ON = 64,
   parameter int THR_OFF = 32,
   parameter int MIN_ON = 3,
   parameter int MIN_OFF = 2,
   parameter int LEN_WIDTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH_IN-1:0] i_data,
   output logic                     o_tone,
   output logic                     o_evt_valid,
   output logic                     o_evt_onset,
   output logic [LEN_WIDTH-1:0]     o_evt_len
);
   localparam int MAX_RUN = MIN_ON > MIN_OFF ? MIN_ON : MIN_OFF;
   localparam int RW = $clog2(MAX_RUN + 1);
   localparam logic [RW-1:0] MON = RW'(MIN_ON);
   localparam logic [RW-1:0] MOFF = RW'(MIN_OFF);
   localparam logic [DATA_WIDTH_IN-1:0] T_ON = DATA_WIDTH_IN'(THR_ON);
   localparam logic [DATA_WIDTH_IN-1:0] T_OFF = DATA_WIDTH_IN'(THR_OFF);
   if (THR_OFF > THR_ON) begin : g_bad_thr
      $error("tone_qualifier: THR_OFF must not exceed THR_ON");
   end
   if (MIN_ON < 1 || MIN_OFF < 1) begin : g_bad_min
      $error("tone_qualifier: MIN_ON and MIN_OFF must be at least 1");
   end
   tone_state_t state, state_n;
   logic [RW-1:0] run, run_n, inc;
   logic [LEN_WIDTH-1:0] len, len_n;
   logic clr, en, tone_n, evt_n, onset_n, hi, lo;
   assign hi = i_data >= T_ON;
   assign lo = i_data < T_OFF;
   // len counts committed tone samples; an aborted release run is folded in all at once
   sat_counter #(.W(LEN_WIDTH), .IW(RW)) u_len (
      .clk(i_clk), .rst(i_rst), .clr(clr), .en(en), .inc(inc), .q(len)
   );
   always_comb begin
      state_n = state;
      run_n = run;
      clr = 1'b0;
      en = 1'b0;
      inc = RW'(1);
      tone_n = o_tone;
      evt_n = 1'b0;
      onset_n = o_evt_onset;
      len_n = o_evt_len;
      if (i_valid)
         case (state)
            IDLE: if (hi) begin
               en = 1'b1;
               if (MIN_ON == 1) begin
                  state_n = ON;
                  tone_n = 1'b1;
                  evt_n = 1'b1;
                  onset_n = EVT_ONSET;
                  len_n = LEN_WIDTH'(MIN_ON);
               end else begin
                  state_n = ATTACK;
                  run_n = RW'(1);
               end
            end
            ATTACK: if (hi) begin
               en = 1'b1;
               run_n = run + RW'(1);
               if (run + RW'(1) == MON) begin
                  state_n = ON;
                  run_n = '0;
                  tone_n = 1'b1;
                  evt_n = 1'b1;
                  onset_n = EVT_ONSET;
                  len_n = LEN_WIDTH'(MIN_ON);
               end
            end else begin
               state_n = IDLE;
               run_n = '0;
               clr = 1'b1;
            end
            ON: if (!lo) en = 1'b1;
            else if (MIN_OFF == 1) begin
               state_n = IDLE;
               clr = 1'b1;
               tone_n = 1'b0;
               evt_n = 1'b1;
               onset_n = EVT_OFFSET;
               len_n = len;
            end else begin
               state_n = RELEASE;
               run_n = RW'(1);
            end
            RELEASE: if (lo) begin
               run_n = run + RW'(1);
               if (run + RW'(1) == MOFF) begin
                  state_n = IDLE;
                  run_n = '0;
                  clr = 1'b1;
                  tone_n = 1'b0;
                  evt_n = 1'b1;
                  onset_n = EVT_OFFSET;
                  len_n = len;
               end
            end else begin
               state_n = ON;
               run_n = '0;
               en = 1'b1;
               inc = run + RW'(1);
            end
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state <= IDLE;
         run <= '0;
         o_tone <= 1'b0;
         o_evt_valid <= 1'b0;
         o_evt_onset <= 1'b0;
         o_evt_len <= '0;
      end else begin
         state <= state_n;
         run <= run_n;
         o_tone <= tone_n;
         o_evt_valid <= evt_n;
         o_evt_onset <= onset_n;
         o_evt_len <= len_n;
      end
endmodule

// File: tb/tb_tone_qualifier.sv
// tb_tone_qualifier: directed plus random stimulus against a run/duration model, two length widths
module tb_tone_qualifier;
   localparam int THR_ON = 64, THR_OFF = 32, MIN_ON = 3, MIN_OFF = 2;
   logic clk = 1'b0;
   logic rst = 1'b1, valid = 1'b0;
   logic [7:0] data = '0;
   logic tone_a, ev_a, on_a, tone_b, ev_b, on_b;
   logic [15:0] len_a;
   logic [3:0] len_b;
   int checks = 0, errors = 0;
   int cap [2] = '{65535, 15};
   bit m_tone;
   int hi_run, lo_run, dur;
   bit e_ev, e_on;
   int e_len [2];
   always #5 clk = ~clk;
   tone_qualifier #(.LEN_WIDTH(16)) u_a (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
      .o_tone(tone_a), .o_evt_valid(ev_a), .o_evt_onset(on_a), .o_evt_len(len_a)
   );
   tone_qualifier #(.LEN_WIDTH(4)) u_b (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
      .o_tone(tone_b), .o_evt_valid(ev_b), .o_evt_onset(on_b), .o_evt_len(len_b)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask
   // duration = every sample since the tone began, minus the completing release run
   task automatic model(input bit r, input bit v, input int d);
      e_ev = 0;
      if (r) begin
         m_tone = 0; hi_run = 0; lo_run = 0; dur = 0;
         e_on = 0; e_len[0] = 0; e_len[1] = 0;
      end else if (v) begin
         if (!m_tone) begin
            hi_run = d >= THR_ON ? hi_run + 1 : 0;
            if (hi_run == MIN_ON) begin
               m_tone = 1; dur = MIN_ON; hi_run = 0; lo_run = 0;
               e_ev = 1; e_on = 1; e_len[0] = MIN_ON; e_len[1] = MIN_ON;
            end
         end else begin
            dur++;
            lo_run = d < THR_OFF ? lo_run + 1 : 0;
            if (lo_run == MIN_OFF) begin
               m_tone = 0; e_ev = 1; e_on = 0;
               for (int k = 0; k < 2; k++)
                  e_len[k] = dur - MIN_OFF > cap[k] ? cap[k] : dur - MIN_OFF;
               dur = 0; lo_run = 0;
            end
         end
      end
   endtask
   task automatic beat(input bit r, input bit v, input int d);
      rst = r; valid = v; data = 8'(d);
      model(r, v, d);
      @(posedge clk);
      #1;
      chk("tone_a", 32'(tone_a), 32'(m_tone));
      chk("evt_valid_a", 32'(ev_a), 32'(e_ev));
      chk("evt_onset_a", 32'(on_a), 32'(e_on));
      chk("evt_len_a", 32'(len_a), 32'(e_len[0]));
      chk("tone_b", 32'(tone_b), 32'(m_tone));
      chk("evt_valid_b", 32'(ev_b), 32'(e_ev));
      chk("evt_onset_b", 32'(on_b), 32'(e_on));
      chk("evt_len_b", 32'(len_b), 32'(e_len[1]));
   endtask
   task automatic seq(input int vals[$]);
      foreach (vals[i]) beat(0, 1, vals[i]);
   endtask
   initial begin
      for (int i = 0; i < 3; i++) beat(1, i[0], 70);
      seq('{70, 70, 70});
      chk("onset_seen", 32'(on_a & tone_a), 32'd1);
      seq('{10, 10});
      seq('{70, 70, 50, 70, 70, 70});
      seq('{10, 10});
      seq('{70, 70, 70, 50, 50, 50, 50, 50, 10, 40, 10, 10});
      chk("release_len", 32'(len_a), 32'd10);
      beat(0, 1, 70);
      for (int i = 0; i < 4; i++) beat(0, 0, 10);
      beat(0, 1, 70);
      beat(0, 0, 0);
      beat(0, 1, 70);
      seq('{10, 10});
      for (int i = 0; i < 20; i++) beat(0, 1, 70);
      seq('{10, 10});
      chk("sat_len_b", 32'(len_b), 32'd15);
      chk("full_len_a", 32'(len_a), 32'd20);
      seq('{70, 70, 70, 70});
      beat(1, 1, 10);
      beat(0, 1, 10);
      beat(0, 1, 10);
      for (int i = 0; i < 3000; i++) begin
         int d;
         d = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) :
             $urandom_range(0, 1) == 0 ? $urandom_range(THR_OFF - 4, THR_ON + 4) :
             m_tone ? $urandom_range(40, 200) : $urandom_range(60, 200);
         beat($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, d);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
